// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR ADC controller.
// The trial-length helper ties bit-trial duration to the comparator synchronizer depth.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;

  localparam int SAR_WIDTH_DEF         = 8;
  localparam int SAR_SAMPLE_CYCLES_DEF = 4;
  localparam int SAR_SYNC_STAGES_DEF   = 2;

  // A trial must outlast the synchronizer latency so the decision sees the current DAC code.
  function automatic int sar_trial_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/sar_sync.sv
// N-stage synchronizer for the asynchronous comparator output.
// All stages clear to 0 on reset.
module sar_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the raw comparator level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, runs WIDTH bit trials against the
// synchronized comparator, and publishes the resolved code with a one-cycle valid pulse.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH_DEF,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SAR_SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cont,
  input  logic             cmp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int T       = sar_trial_len(SYNC_STAGES);
  localparam int CNT_MAX = (SAMPLE_CYCLES > T) ? SAMPLE_CYCLES : T;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_CODE = WIDTH'(1);

  sar_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sample_en_q, sample_en_d;
  logic [WIDTH-1:0] dac_code_q, dac_code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cmp_s;
  logic [WIDTH-1:0] trial_mask_s;
  logic [WIDTH-1:0] decided_s;

  sar_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cmp_in),
    .q_o   (cmp_s)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sample_en_d  = 1'b0;
    dac_code_d   = dac_code_q;
    result_d     = result_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    trial_mask_s = ONE_CODE << bit_q;
    // The current trial code already carries the trial bit; drop it if Vin < Vdac.
    decided_s    = cmp_s ? dac_code_q : (dac_code_q & ~trial_mask_s);

    if (!ena) begin
      state_d    = IDLE;
      cnt_d      = '0;
      bit_d      = '0;
      dac_code_d = '0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = SAMPLE;
            cnt_d       = '0;
            sample_en_d = 1'b1;
            dac_code_d  = '0;
            busy_d      = 1'b1;
          end else begin
            dac_code_d = '0;
            busy_d     = 1'b0;
          end
        end
        SAMPLE: begin
          if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_d    = CONVERT;
            cnt_d      = '0;
            bit_d      = BIT_W'(WIDTH - 1);
            dac_code_d = ONE_CODE << (WIDTH - 1);
          end else begin
            cnt_d       = cnt_q + CNT_W'(1);
            sample_en_d = 1'b1;
          end
        end
        CONVERT: begin
          if (cnt_q == CNT_W'(T - 1)) begin
            cnt_d = '0;
            if (bit_q == BIT_W'(0)) begin
              state_d    = DONE;
              dac_code_d = decided_s;
              result_d   = decided_s;
              valid_d    = 1'b1;
            end else begin
              bit_d      = bit_q - BIT_W'(1);
              dac_code_d = decided_s | (trial_mask_s >> 1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (cont) begin
            state_d     = SAMPLE;
            cnt_d       = '0;
            sample_en_d = 1'b1;
            dac_code_d  = '0;
            busy_d      = 1'b1;
          end else begin
            state_d    = IDLE;
            dac_code_d = '0;
            busy_d     = 1'b0;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          bit_d      = '0;
          dac_code_d = '0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sample_en_q <= 1'b0;
      dac_code_q  <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sample_en_q <= sample_en_d;
      dac_code_q  <= dac_code_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sample_en = sample_en_q;
  assign dac_code  = dac_code_q;
  assign result    = result_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller for the on-chip analog SAR ADC core that sits on the ua[5:0] pins of the analog top.
- Drives the sample switch and the capacitive-DAC trial code into the analog core.
- Resolves the comparator decision one bit at a time.
- Presents the finished code to the digital pins (uo_out), with busy/valid status.
- Sits directly upstream/downstream of the analog core: it feeds the DAC code and consumes the comparator output.

Parameters:
- WIDTH, 8: conversion resolution in bits.
- SAMPLE_CYCLES, 4: clock cycles the sample switch stays closed; legal range ≥1.
- SYNC_STAGES, 2: flip-flop stages in the comparator synchronizer; legal range ≥2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; low acts as a synchronous abort.
- start  input  1  level request; sampled only in IDLE.
- cont  input  1  continuous mode; sampled in DONE.
- cmp_in  input  1  raw analog comparator output, asynchronous; 1 means Vin ≥ Vdac.
- sample_en  output  1  closes the sample/hold switch.
- dac_code  output  WIDTH  trial code driven to the capacitive DAC.
- result  output  WIDTH  last completed conversion.
- valid  output  1  one-cycle pulse when result updates.
- busy  output  1  high in every non-IDLE state.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, sample_en=0, dac_code=0, result=0, valid=0, busy=0, synchronizer flops=0. Reset asserted mid-operation forces these values immediately (asynchronously).
- All outputs are registered.
- cmp_in is sampled every cycle through SYNC_STAGES flops; cmp_s denotes the synchronizer output.
- IDLE: outputs idle.
  - start=1 && ena=1 at an edge → SAMPLE.
- SAMPLE: sample_en=1, dac_code=0, for exactly SAMPLE_CYCLES cycles.
  - Then → CONVERT with bit index i=WIDTH-1.
  - sample_en drops on the same edge that CONVERT begins.
- CONVERT: each bit trial lasts T=SYNC_STAGES+1 cycles.
  - First trial cycle: dac_code = kept bits | (1<<i).
  - Last trial cycle: bit i is kept if cmp_s=1, cleared if 0. The new code is loaded on that same edge.
  - After bit 0 is decided → DONE.
- DONE: lasts one cycle.
  - result = final code; valid=1; dac_code holds the final code.
  - Next state: SAMPLE if cont=1 && ena=1, else IDLE.
- Latency: start accepted at edge k → valid high in the cycle after edge k + SAMPLE_CYCLES + WIDTH*T; with defaults, k+28.
- Continuous mode: valid-to-valid period is SAMPLE_CYCLES + WIDTH*T + 1 = 29 cycles with defaults.
- start while busy is ignored; no queuing.
- ena=0 in any state → IDLE on the next edge.
  - sample_en=0, dac_code=0, no valid, result unchanged.
- valid is never asserted for two consecutive cycles.
- result changes only in the cycle where valid=1.
- Boundary codes: all-zero and all-ones inputs must resolve exactly. No extra trial and no overflow; only the WIDTH bits of dac_code exist.

Decomposition:
- Package sar_pkg holds:
  - state enum {IDLE, SAMPLE, CONVERT, DONE};
  - default parameter constants;
  - localparam function for trial length T.
- One sub-module, sar_sync (parameterised N-flop synchronizer for cmp_in, async active-low reset to 0), instantiated once.
- Bit index and trial-cycle counters stay in sar_adc_ctrl.

Test Plan:
- Bench comparator model for all scenarios: cmp_in = (vin_code ≥ dac_code), combinational.
- Scenario 1: vin_code=0xA5, start pulse at edge k → busy=1 from k; sample_en high for 4 cycles; dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 (3 cycles each); valid after edge k+28; result=0xA5.
- Scenario 2: vin_code=0x00 and then 0xFF → result 0x00 and 0xFF respectively; exactly one valid pulse each; busy=0 afterwards.
- Scenario 3: cont=1 with vin_code stepping 0x3C then 0xC3 → valid pulses exactly 29 cycles apart; results 0x3C then 0xC3; busy stays 1 between them.
- Scenario 4: start re-pulsed at cycle 10 of a conversion → ignored; single valid at k+28.
- Scenario 5: ena=0 at cycle 15 of a conversion → IDLE next cycle; busy=0, dac_code=0; result keeps its prior value (0xA5); no valid.
- Scenario 6: rst_n low asynchronously mid-CONVERT → all outputs 0 without waiting for clk; after release, a fresh start converts normally.
